// File: rtl/left_shift_seq_pkg.sv
// Shared shifter definitions: FSM state encoding, default operand width
// and the helper that sizes the shift-amount field from the operand width.
package shifter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;

    // Shift-amount width needed to express every distance below WIDTH
    function automatic int amt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/left_shift_seq_if.sv
// Request/result bundle of the sequential left shifter.
// master drives the request side, slave is the shifter itself.
interface left_shift_seq_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = amt_width(WIDTH)
) ();

    logic             strt;
    logic [WIDTH-1:0] src;
    logic [AMT_W-1:0] amt;
    logic             rot;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic             done;

    modport master (
        output strt, src, amt, rot,
        input  res, busy, done
    );

    modport slave (
        input  strt, src, amt, rot,
        output res, busy, done
    );

endinterface

// File: rtl/left_shift_seq_stage.sv
// left_shift_stage: one combinational power-of-two left shift stage.
// Shifts data left by 2^stage, zero filled; when LEFT_SHIFT_ROT_EN is
// defined and rot is set, the bits leaving the MSB wrap into the LSBs.
module left_shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = amt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] stage,
    input  logic             rot,
    output logic [WIDTH-1:0] shifted
);

    logic [31:0]      dist_s;
    logic [WIDTH-1:0] shl_s;

`ifdef LEFT_SHIFT_ROT_EN
    logic [WIDTH-1:0] wrap_s;
`else
    // Logical-only build: the mode input has no function
    logic unused_rot_s;
    assign unused_rot_s = rot;
`endif

    // Form the stage distance, the zero-filled shift and optional wrap-in
    always_comb begin
        dist_s = 32'd1 << stage;
        shl_s  = data << dist_s;
`ifdef LEFT_SHIFT_ROT_EN
        // dist_s is at most WIDTH/2, so this shift never reaches WIDTH
        wrap_s = data >> (32'(WIDTH) - dist_s);
        if (rot) begin
            shifted = shl_s | wrap_s;
        end else begin
            shifted = shl_s;
        end
`else
        shifted = shl_s;
`endif
    end

endmodule

// File: rtl/left_shift_seq.sv
// left_shift_seq: sequential left shifter/rotator.
// Captures an operand and amount on strt, then applies one power-of-two
// stage per clock for each set bit of the amount (lowest first) and
// publishes the result with a one-cycle done pulse.
// Optional rotate support: define LEFT_SHIFT_ROT_EN.
module left_shift_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic           clk,
    input logic           rst,
    left_shift_seq_if.slave bus
);

    localparam int AMT_W = amt_width(WIDTH);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic [WIDTH-1:0] stage_out_s;
    logic [AMT_W-1:0] rem_r, rem_s;
    logic [AMT_W-1:0] lsb_idx_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             accept_s;
    logic             stage_rot_s;

    // A request is only taken while idle; strt while busy is dropped
    always_comb begin
        accept_s = (state_r == IDLE) && bus.strt;
    end

    // Index of the lowest set bit of the remaining amount
    always_comb begin
        lsb_idx_s = {AMT_W{1'b0}};
        for (int i = AMT_W - 1; i >= 0; i--) begin
            lsb_idx_s = rem_r[i] ? AMT_W'(i) : lsb_idx_s;
        end
    end

`ifdef LEFT_SHIFT_ROT_EN
    logic rot_r;

    // Latch the rotate mode together with the operand
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_r <= 1'b0;
        end else if (accept_s) begin
            rot_r <= bus.rot;
        end else begin
            rot_r <= rot_r;
        end
    end

    assign stage_rot_s = rot_r;
`else
    // Logical-only build: rotate request is ignored
    logic unused_rot_s;
    assign unused_rot_s = bus.rot;
    assign stage_rot_s  = 1'b0;
`endif

    left_shift_stage #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_stage (
        .data    (data_r),
        .stage   (lsb_idx_s),
        .rot     (stage_rot_s),
        .shifted (stage_out_s)
    );

    // Next-state and next-output logic of the shift sequencer
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        rem_s   = rem_r;
        res_s   = res_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    data_s  = bus.src;
                    rem_s   = bus.amt;
                    busy_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_r != {AMT_W{1'b0}}) begin
                    data_s  = stage_out_s;
                    // Clearing the lowest set bit retires the stage just applied
                    rem_s   = rem_r & (rem_r - {{(AMT_W-1){1'b0}}, 1'b1});
                    state_s = SHIFT;
                end else begin
                    res_s   = data_r;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            data_r  <= {WIDTH{1'b0}};
            rem_r   <= {AMT_W{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            rem_r   <= rem_s;
            res_r   <= res_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.res  = res_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_left_shift_seq.sv
// Directed self-checking bench for left_shift_seq (16-bit build).
// Expected results depend on LEFT_SHIFT_ROT_EN where rotate is requested.
module tb_left_shift_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    left_shift_seq_if #(.WIDTH(16)) bus ();

    left_shift_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [15:0] src, input logic [3:0] amt, input logic r);
        bus.strt = s;
        bus.src  = src;
        bus.amt  = amt;
        bus.rot  = r;
    endtask

    // Issue one op, check busy over p+1 cycles, then done/res; ends in done cycle
    task automatic run_op(input string tag, input logic [15:0] src, input logic [3:0] amt,
                          input logic r, input logic [15:0] exp);
        int p;
        p = $countones(amt);
        drive(1'b1, src, amt, r);
        tick();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        for (int i = 0; i <= p; i++) begin
            chk({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
            chk({tag, "_nodone"}, {15'd0, bus.done}, 16'd0);
            tick();
        end
        chk({tag, "_done"}, {15'd0, bus.done}, 16'd1);
        chk({tag, "_idle"}, {15'd0, bus.busy}, 16'd0);
        chk({tag, "_res"}, bus.res, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_res", bus.res, 16'h0000);
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_done", {15'd0, bus.done}, 16'd0);

        run_op("sll4", 16'h00F1, 4'd4, 1'b0, 16'h0F10);
        tick();
        chk("sll4_pulse", {15'd0, bus.done}, 16'd0);
        chk("sll4_hold", bus.res, 16'h0F10);

        run_op("sll15", 16'hABCD, 4'd15, 1'b0, 16'h8000);
`ifdef LEFT_SHIFT_ROT_EN
        run_op("rol15", 16'hABCD, 4'd15, 1'b1, 16'hD5E6);
`else
        run_op("rol15", 16'hABCD, 4'd15, 1'b1, 16'h8000);
`endif
        tick();
        run_op("amt0", 16'h1234, 4'd0, 1'b0, 16'h1234);
`ifdef LEFT_SHIFT_ROT_EN
        run_op("rol1", 16'h8001, 4'd1, 1'b1, 16'h0003);
        run_op("rol5", 16'h1234, 4'd5, 1'b1, 16'h4682);
`else
        run_op("rol1", 16'h8001, 4'd1, 1'b1, 16'h0002);
        run_op("rol5", 16'h1234, 4'd5, 1'b1, 16'h4680);
`endif
        tick();

        // strt during busy is dropped
        drive(1'b1, 16'h0001, 4'd3, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        tick();
        drive(1'b1, 16'hFFFF, 4'd0, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        chk("ign_busy", {15'd0, bus.busy}, 16'd1);
        chk("ign_nodone", {15'd0, bus.done}, 16'd0);
        tick();
        chk("ign_done", {15'd0, bus.done}, 16'd1);
        chk("ign_res", bus.res, 16'h0008);
        // accepted straight from the done cycle
        run_op("b2b", 16'h00F1, 4'd4, 1'b0, 16'h0F10);
        tick();

        // reset aborts an in-flight op
        drive(1'b1, 16'hABCD, 4'd15, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {15'd0, bus.busy}, 16'd0);
        chk("abort_done", {15'd0, bus.done}, 16'd0);
        chk("abort_res", bus.res, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_quiet_done", {15'd0, bus.done}, 16'd0);
            chk("abort_quiet_busy", {15'd0, bus.busy}, 16'd0);
        end

        // rst wins over a simultaneous strt
        rst = 1'b1;
        drive(1'b1, 16'h1234, 4'd0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        chk("rststrt_busy", {15'd0, bus.busy}, 16'd0);
        tick();
        chk("rststrt_nodone", {15'd0, bus.done}, 16'd0);
        chk("rststrt_res", bus.res, 16'h0000);

        run_op("post", 16'h0003, 4'd2, 1'b0, 16'h000C);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/left_shift_seq.md
# left_shift_seq

Sequential left shifter/rotator: the left-direction counterpart to the team's combinational right shifter. It accepts a 16-bit operand and a 4-bit amount on a start strobe. It then applies one power-of-two shift stage per clock, only for the set bits of the amount, and presents the result with a one-cycle done pulse. It serves the datapath for SLL/ROL-class operations, where area matters more than single-cycle latency.

## Interface
- WIDTH, 16: operand width; power of two, ≥ 2
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- strt  input  1  start request; sampled only in IDLE
- src  input  WIDTH  operand, captured on accepted strt
- amt  input  AMT_W  shift amount (AMT_W = log2(WIDTH), 4 by default), captured on accepted strt
- rot  input  1  1 = rotate left, 0 = logical left (zero fill); captured on accepted strt
- res  output  WIDTH  result register; holds last completed result
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when res has just been updated

## Operation
- States:
  - IDLE: strt=1 at an edge → capture src into data_r, amt into rem_r, rot into rot_r; go to SHIFT; busy←1.
  - SHIFT, rem_r≠0: pick i = index of lowest set bit of rem_r. data_r ← data_r shifted left by 2^i, zero-filled, or rotated if rot_r. Clear rem_r[i]. Stay in SHIFT.
  - SHIFT, rem_r=0: res ← data_r; done←1; busy←0; go to IDLE.
- Shift stages are applied in ascending bit order; the result equals a single left shift or rotate by amt.
- Logical: bits shifted past the MSB are discarded; the LSBs are filled with 0. Rotate: bits shifted out of the MSB re-enter at the LSB.
- strt while busy: ignored, with no effect on state or outputs.
- amt=0: no shift stages; res=src.

## Timing
- Reset values: res=0, busy=0, done=0, state=IDLE, data_r=0, rem_r=0.
- strt accepted at edge k:
  - busy is high from after edge k until after edge k+p+1, where p = popcount(amt).
  - res and done are valid after edge k+p+1.
  - Latency ranges from 1 cycle (amt=0) to AMT_W+1 cycles (amt all-ones; 5 by default).
- done is high for exactly one cycle. res is stable from that cycle until the next completion.
- Back-to-back: the cycle in which done=1 is already IDLE. A strt sampled at that edge is accepted, giving no bubble between operations.
- rst mid-operation: at the next edge, abort to IDLE; all outputs return to reset values and the in-flight result is discarded.
- rst and strt together: rst wins.

## Configuration
- LEFT_SHIFT_ROT_EN defined: rotate supported as described; rot is captured and honoured.
- LEFT_SHIFT_ROT_EN undefined:
  - The rot port still exists but is ignored; the unit is logical-left only.
  - rot_r and the wrap-around muxing are not synthesized.

## Structure
- Shared package shifter_pkg:
  - state_t enum {IDLE, SHIFT}
  - localparam DEF_WIDTH = 16
  - a function for AMT_W = $clog2(WIDTH)
- Sub-module left_shift_stage: purely combinational.
  - Inputs: data, stage index, rot.
  - Output: data shifted or rotated left by 2^stage.
  - Instantiated once; its stage index is the lowest-set-bit encoder output of rem_r.
- Top level holds the FSM, data_r, rem_r, rot_r and the output registers.

## Test plan
- src=0x00F1, amt=4, rot=0, strt at edge k → done after edge k+2, res=0x0F10; busy high for exactly 2 cycles.
- src=0xABCD, amt=15, rot=0 → done after edge k+5, res=0x8000. With the macro defined and rot=1 → res=0xD5E6.
- src=0x1234, amt=0 → done after edge k+1, res=0x1234; busy high 1 cycle.
- src=0x8001, amt=1, rot=1 → res=0x0003 (macro defined) or res=0x0002 (macro undefined).
- strt with src=0xFFFF during busy of op (src=0x0001, amt=3) → ignored; res=0x0008. A new strt in the done cycle is accepted, and its done arrives with no idle gap.
- rst asserted one cycle after an op with amt=15 is accepted → next cycle busy=0, done=0, res=0; no done pulse follows.
